// File: rtl/regfile_write_arbiter_if.sv
// Writeback requester bus and regfile write port shared by the arbiter and its clients.
interface regfile_write_arbiter_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int NREGS  = 16
);
  logic              a_valid;
  logic              a_ready;
  logic [ADDR_W-1:0] a_reg;
  logic [DATA_W-1:0] a_data;
  logic              b_valid;
  logic              b_ready;
  logic [ADDR_W-1:0] b_reg;
  logic [DATA_W-1:0] b_data;
  logic              write;
  logic [ADDR_W-1:0] writeReg;
  logic [DATA_W-1:0] writeData;
  logic [NREGS-1:0]  pending;

  modport master (
    output a_valid, a_reg, a_data, b_valid, b_reg, b_data,
    input  a_ready, b_ready, write, writeReg, writeData, pending
  );

  modport slave (
    input  a_valid, a_reg, a_data, b_valid, b_reg, b_data,
    output a_ready, b_ready, write, writeReg, writeData, pending
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Two-requester regfile write arbiter: A (ALU) has priority, B (load) is protected
// by a bounded win counter, same-register writes commit in acceptance order.
module regfile_write_arbiter #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 4,
  parameter int NREGS   = 16,
  parameter int MAX_WIN = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  regfile_write_arbiter_if.slave  bus
);

  localparam int CNT_W = (MAX_WIN < 1) ? 1 : $clog2(MAX_WIN + 1);
  localparam logic [CNT_W-1:0] WIN_MAX = CNT_W'(MAX_WIN);

  typedef struct packed {
    logic [ADDR_W-1:0] rg;
    logic [DATA_W-1:0] dat;
  } entry_t;

  entry_t            a_q, a_d, b_q, b_d, a_in, b_in;
  logic              a_full_q, a_full_d, b_full_q, b_full_d;
  logic              b_older_q, b_older_d;
  logic [CNT_W-1:0]  win_cnt_q, win_cnt_d;
  logic              write_q, write_d;
  logic [ADDR_W-1:0] wreg_q, wreg_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic grant_a, grant_b, a_rdy, b_rdy, a_acc, b_acc;

  assign a_in = '{rg: bus.a_reg, dat: bus.a_data};
  assign b_in = '{rg: bus.b_reg, dat: bus.b_data};

  // Arbitration over the registered slots only.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (a_full_q && b_full_q) begin
      if (a_q.rg == b_q.rg) begin
        grant_b = b_older_q;
        grant_a = !b_older_q;
      end else begin
        grant_b = (win_cnt_q == WIN_MAX);
        grant_a = (win_cnt_q != WIN_MAX);
      end
    end else if (a_full_q) begin
      grant_a = 1'b1;
    end else if (b_full_q) begin
      grant_b = 1'b1;
    end
  end

  assign a_rdy = !rst && (!a_full_q || grant_a);
  assign b_rdy = !rst && (!b_full_q || grant_b);
  assign a_acc = bus.a_valid && a_rdy;
  assign b_acc = bus.b_valid && b_rdy;

  always_comb begin
    a_full_d  = a_acc || (a_full_q && !grant_a);
    b_full_d  = b_acc || (b_full_q && !grant_b);
    a_d       = a_acc ? a_in : a_q;
    b_d       = b_acc ? b_in : b_q;

    // b_older means B's held entry predates A's; a same-edge pair counts A as older.
    b_older_d = 1'b0;
    if (a_full_d && b_full_d) begin
      if (b_acc)      b_older_d = 1'b0;
      else if (a_acc) b_older_d = 1'b1;
      else            b_older_d = b_older_q;
    end

    win_cnt_d = win_cnt_q;
    if (grant_b || !b_full_q)
      win_cnt_d = '0;
    else if (grant_a && (win_cnt_q != WIN_MAX))
      win_cnt_d = win_cnt_q + 1'b1;

    write_d = grant_a || grant_b;
    wreg_d  = wreg_q;
    wdata_d = wdata_q;
    if (grant_b) begin
      wreg_d  = b_q.rg;
      wdata_d = b_q.dat;
    end else if (grant_a) begin
      wreg_d  = a_q.rg;
      wdata_d = a_q.dat;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q       <= '0;
      b_q       <= '0;
      a_full_q  <= 1'b0;
      b_full_q  <= 1'b0;
      b_older_q <= 1'b0;
      win_cnt_q <= '0;
      write_q   <= 1'b0;
      wreg_q    <= '0;
      wdata_q   <= '0;
    end else begin
      a_q       <= a_d;
      b_q       <= b_d;
      a_full_q  <= a_full_d;
      b_full_q  <= b_full_d;
      b_older_q <= b_older_d;
      win_cnt_q <= win_cnt_d;
      write_q   <= write_d;
      wreg_q    <= wreg_d;
      wdata_q   <= wdata_d;
    end
  end

  assign bus.a_ready   = a_rdy;
  assign bus.b_ready   = b_rdy;
  assign bus.write     = write_q;
  assign bus.writeReg  = wreg_q;
  assign bus.writeData = wdata_q;

  // A register stays pending from slot capture until its write has been presented.
  for (genvar r = 0; r < NREGS; r++) begin : g_pend
    assign bus.pending[r] = (a_full_q && (a_q.rg == ADDR_W'(r))) ||
                            (b_full_q && (b_q.rg == ADDR_W'(r))) ||
                            (write_q  && (wreg_q == ADDR_W'(r)));
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed vector bench for regfile_write_arbiter: per-cycle table plus a reset sequence.
module tb_regfile_write_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  regfile_write_arbiter_if #(.DATA_W(16), .ADDR_W(4), .NREGS(16)) bus ();

  regfile_write_arbiter #(.DATA_W(16), .ADDR_W(4), .NREGS(16), .MAX_WIN(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic        av;
    logic [3:0]  ar;
    logic [15:0] ad;
    logic        bv;
    logic [3:0]  br;
    logic [15:0] bd;
    logic        ear;
    logic        ebr;
    logic        ew;
    logic [3:0]  ewr;
    logic [15:0] ewd;
    logic [15:0] epend;
  } vec_t;

  vec_t vq[$];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic void add(input logic av, input logic [3:0] ar, input logic [15:0] ad,
                              input logic bv, input logic [3:0] br, input logic [15:0] bd,
                              input logic ear, input logic ebr,
                              input logic ew, input logic [3:0] ewr, input logic [15:0] ewd,
                              input logic [15:0] epend);
    vec_t v;
    v.av = av; v.ar = ar; v.ad = ad; v.bv = bv; v.br = br; v.bd = bd;
    v.ear = ear; v.ebr = ebr; v.ew = ew; v.ewr = ewr; v.ewd = ewd; v.epend = epend;
    vq.push_back(v);
  endfunction

  task automatic drive(input logic av, input logic [3:0] ar, input logic [15:0] ad,
                       input logic bv, input logic [3:0] br, input logic [15:0] bd);
    bus.a_valid = av; bus.a_reg = ar; bus.a_data = ad;
    bus.b_valid = bv; bus.b_reg = br; bus.b_data = bd;
  endtask

  initial begin
    drive(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0);

    // A alone
    add(1, 4'd1, 16'h0002, 0, 4'd0, 16'h0,    1, 1, 0, 4'd0, 16'h0,    16'h0002);
    add(0, 4'd0, 16'h0000, 0, 4'd0, 16'h0,    1, 1, 1, 4'd1, 16'h0002, 16'h0002);
    add(0, 4'd0, 16'h0000, 0, 4'd0, 16'h0,    1, 1, 0, 4'd0, 16'h0,    16'h0000);
    // both streaming, different regs: A,A,A,B,A,A,A,B
    add(1, 4'd3, 16'h0A00, 1, 4'd4, 16'h0B00, 1, 1, 0, 4'd0, 16'h0,    16'h0018);
    add(1, 4'd3, 16'h0A01, 1, 4'd4, 16'h0B01, 1, 0, 1, 4'd3, 16'h0A00, 16'h0018);
    add(1, 4'd3, 16'h0A02, 1, 4'd4, 16'h0B02, 1, 0, 1, 4'd3, 16'h0A01, 16'h0018);
    add(1, 4'd3, 16'h0A03, 1, 4'd4, 16'h0B03, 1, 0, 1, 4'd3, 16'h0A02, 16'h0018);
    add(1, 4'd3, 16'h0A04, 1, 4'd4, 16'h0B04, 0, 1, 1, 4'd4, 16'h0B00, 16'h0018);
    add(1, 4'd3, 16'h0A05, 1, 4'd4, 16'h0B05, 1, 0, 1, 4'd3, 16'h0A03, 16'h0018);
    add(1, 4'd3, 16'h0A06, 1, 4'd4, 16'h0B06, 1, 0, 1, 4'd3, 16'h0A05, 16'h0018);
    add(1, 4'd3, 16'h0A07, 1, 4'd4, 16'h0B07, 1, 0, 1, 4'd3, 16'h0A06, 16'h0018);
    add(1, 4'd3, 16'h0A08, 1, 4'd4, 16'h0B08, 0, 1, 1, 4'd4, 16'h0B04, 16'h0018);
    add(0, 4'd0, 16'h0000, 0, 4'd0, 16'h0,    1, 0, 1, 4'd3, 16'h0A07, 16'h0018);
    add(0, 4'd0, 16'h0000, 0, 4'd0, 16'h0,    1, 1, 1, 4'd4, 16'h0B08, 16'h0010);
    add(0, 4'd0, 16'h0000, 0, 4'd0, 16'h0,    1, 1, 0, 4'd0, 16'h0,    16'h0000);
    // simultaneous accept, same reg 2
    add(1, 4'd2, 16'h0004, 1, 4'd2, 16'h0005, 1, 1, 0, 4'd0, 16'h0,    16'h0004);
    add(0, 4'd0, 16'h0000, 0, 4'd0, 16'h0,    1, 0, 1, 4'd2, 16'h0004, 16'h0004);
    add(0, 4'd0, 16'h0000, 0, 4'd0, 16'h0,    1, 1, 1, 4'd2, 16'h0005, 16'h0004);
    add(0, 4'd0, 16'h0000, 0, 4'd0, 16'h0,    1, 1, 0, 4'd0, 16'h0,    16'h0000);
    // age ordering: older B reg5 beats newer A reg5
    add(1, 4'd6, 16'h0060, 0, 4'd0, 16'h0,    1, 1, 0, 4'd0, 16'h0,    16'h0040);
    add(1, 4'd6, 16'h0061, 1, 4'd5, 16'h0007, 1, 1, 1, 4'd6, 16'h0060, 16'h0060);
    add(1, 4'd5, 16'h0008, 0, 4'd0, 16'h0,    1, 0, 1, 4'd6, 16'h0061, 16'h0060);
    add(0, 4'd0, 16'h0000, 0, 4'd0, 16'h0,    0, 1, 1, 4'd5, 16'h0007, 16'h0020);
    add(0, 4'd0, 16'h0000, 0, 4'd0, 16'h0,    1, 1, 1, 4'd5, 16'h0008, 16'h0020);
    add(0, 4'd0, 16'h0000, 0, 4'd0, 16'h0,    1, 1, 0, 4'd0, 16'h0,    16'h0000);
    // backpressure: A held while B drains, data change to FFFF is ignored
    add(1, 4'd9,  16'h0090, 0, 4'd0,  16'h0,    1, 1, 0, 4'd0,  16'h0,    16'h0200);
    add(1, 4'd9,  16'h0091, 1, 4'd10, 16'h00A0, 1, 1, 1, 4'd9,  16'h0090, 16'h0600);
    add(1, 4'd10, 16'h1234, 0, 4'd0,  16'h0,    1, 0, 1, 4'd9,  16'h0091, 16'h0600);
    add(1, 4'd10, 16'hFFFF, 0, 4'd0,  16'h0,    0, 1, 1, 4'd10, 16'h00A0, 16'h0400);
    add(0, 4'd0,  16'h0000, 0, 4'd0,  16'h0,    1, 1, 1, 4'd10, 16'h1234, 16'h0400);
    add(0, 4'd0,  16'h0000, 0, 4'd0,  16'h0,    1, 1, 0, 4'd0,  16'h0,    16'h0000);

    // reset state
    rst = 1'b1;
    @(negedge clk);
    drive(1'b1, 4'd7, 16'h0077, 1'b1, 4'd8, 16'h0088);
    #1;
    chk("rst_a_ready", 32'(bus.a_ready), 32'd0);
    chk("rst_b_ready", 32'(bus.b_ready), 32'd0);
    @(posedge clk); #1;
    chk("rst_write",     32'(bus.write),     32'd0);
    chk("rst_writeReg",  32'(bus.writeReg),  32'd0);
    chk("rst_writeData", 32'(bus.writeData), 32'd0);
    chk("rst_pending",   32'(bus.pending),   32'd0);
    @(negedge clk);
    drive(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0);
    rst = 1'b0;

    foreach (vq[i]) begin
      @(negedge clk);
      drive(vq[i].av, vq[i].ar, vq[i].ad, vq[i].bv, vq[i].br, vq[i].bd);
      #1;
      chk($sformatf("v%0d_a_ready", i), 32'(bus.a_ready), 32'(vq[i].ear));
      chk($sformatf("v%0d_b_ready", i), 32'(bus.b_ready), 32'(vq[i].ebr));
      @(posedge clk); #1;
      chk($sformatf("v%0d_write", i), 32'(bus.write), 32'(vq[i].ew));
      if (vq[i].ew) begin
        chk($sformatf("v%0d_writeReg", i),  32'(bus.writeReg),  32'(vq[i].ewr));
        chk($sformatf("v%0d_writeData", i), 32'(bus.writeData), 32'(vq[i].ewd));
      end
      chk($sformatf("v%0d_pending", i), 32'(bus.pending), 32'(vq[i].epend));
    end

    // mid-operation reset with both slots full and a write in flight
    @(negedge clk);
    drive(1'b1, 4'd3, 16'h00C0, 1'b1, 4'd4, 16'h00D0);
    @(posedge clk); #1;
    chk("mr_fill_pending", 32'(bus.pending), 32'h0018);
    @(negedge clk);
    drive(1'b1, 4'd3, 16'h00C1, 1'b1, 4'd4, 16'h00D1);
    @(posedge clk); #1;
    chk("mr_fill_write", 32'(bus.write), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mr_a_ready", 32'(bus.a_ready), 32'd0);
    chk("mr_b_ready", 32'(bus.b_ready), 32'd0);
    @(posedge clk); #1;
    chk("mr_write",   32'(bus.write),   32'd0);
    chk("mr_pending", 32'(bus.pending), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0);
    #1;
    chk("mr_post_a_ready", 32'(bus.a_ready), 32'd1);
    chk("mr_post_b_ready", 32'(bus.b_ready), 32'd1);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk($sformatf("mr_stale_write%0d", k),   32'(bus.write),   32'd0);
      chk($sformatf("mr_stale_pending%0d", k), 32'(bus.pending), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
